// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) producing {remainder, quotient}.
// Optional `DIV_EARLY_OUT_EN: skip iterations when |dividend| < |divisor|.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   dvd_orig_q;
  logic               neg_quot_q;
  logic               neg_rem_q;
  logic               early_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;

  logic [WIDTH-1:0]   abs_dvd;
  logic [WIDTH-1:0]   abs_dvs;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quot_d;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               early_hit;

  // quot_q starts as |dividend|; its MSBs shift into the partial remainder
  // while quotient bits shift in at the bottom.
  always_comb begin
    abs_dvd = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    abs_dvs = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    trial   = {rem_q, quot_q[WIDTH-1]};
    diff    = trial - {1'b0, dvs_q};
    if (diff[WIDTH]) begin
      rem_d  = trial[WIDTH-1:0];
      quot_d = {quot_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_d  = diff[WIDTH-1:0];
      quot_d = {quot_q[WIDTH-2:0], 1'b1};
    end
    quot_fix  = neg_quot_q ? -quot_d : quot_d;
    rem_fix   = neg_rem_q  ? -rem_d  : rem_d;
    early_hit = 1'b0;
`ifdef DIV_EARLY_OUT_EN
    early_hit = (opdata2_i != '0) && (abs_dvd < abs_dvs);
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      dvd_orig_q <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      early_q    <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else if (annul_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            quot_q     <= abs_dvd;
            rem_q      <= '0;
            dvs_q      <= abs_dvs;
            dvd_orig_q <= opdata1_i;
            neg_quot_q <= signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_q  <= signed_i && opdata1_i[WIDTH-1];
            early_q    <= early_hit;
            cnt_q      <= '0;
            // Divide-by-zero and early-out share the one-cycle short path.
            state_q    <= ((opdata2_i == '0) || early_hit) ? S_DIVZERO : S_ON;
          end
        end
        S_DIVZERO: begin
          if (!start_i) begin
            state_q <= S_IDLE;
          end else begin
            state_q  <= S_END;
            ready_q  <= 1'b1;
            result_q <= early_q ? {dvd_orig_q, {WIDTH{1'b0}}}
                                : {dvd_orig_q, {WIDTH{1'b1}}};
          end
        end
        S_ON: begin
          if (!start_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
              state_q  <= S_END;
              ready_q  <= 1'b1;
              result_q <= {rem_fix, quot_fix};
            end
          end
        end
        S_END: begin
          if (!start_i) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            result_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign stall_o  = start_i & ~ready_q;

endmodule
